// File: rtl/junction_pkg.sv
// rtl/junction_pkg.sv - shared phase, aspect and lamp definitions for the junction scheduler
package junction_pkg;

    localparam logic [1:0] PHASE1 = 2'd0;
    localparam logic [1:0] PHASE2 = 2'd1;
    localparam logic [1:0] PHASE3 = 2'd2;

    typedef enum logic [1:0] {
        ASP_RY = 2'b00,
        ASP_G  = 2'b01,
        ASP_Y  = 2'b10,
        ASP_R  = 2'b11
    } aspect_t;

    localparam logic [2:0] LAMP_RED        = 3'b100;
    localparam logic [2:0] LAMP_YELLOW     = 3'b010;
    localparam logic [2:0] LAMP_GREEN      = 3'b001;
    localparam logic [2:0] LAMP_RED_YELLOW = 3'b110;

    function automatic logic [1:0] phase_inc(input logic [1:0] p);
        return (p == PHASE3) ? PHASE1 : p + 2'd1;
    endfunction

    function automatic logic [2:0] phase_onehot(input logic [1:0] p);
        case (p)
            PHASE1:  return 3'b001;
            PHASE2:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] lamp_of(input logic [1:0] a);
        case (a)
            ASP_RY:  return LAMP_RED_YELLOW;
            ASP_G:   return LAMP_GREEN;
            ASP_Y:   return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running clock divider producing one tick every TICK_DIV clocks
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/junction_phase_scheduler.sv
// rtl/junction_phase_scheduler.sv - demand-actuated round-robin phase scheduler with preemption
module junction_phase_scheduler
    import junction_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int RY_TICKS    = 1,
    parameter int MIN_G_TICKS = 4,
    parameter int MAX_G_TICKS = 16,
    parameter int Y_TICKS     = 1,
    parameter int R_TICKS     = 1,
    parameter int REST_PHASE  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       preempt,
    input  logic [1:0] preempt_phase,
    output logic [1:0] phase,
    output logic [1:0] aspect,
    output logic [2:0] grant,
    output logic       served
);

    localparam logic [1:0] S_RY = ASP_RY;
    localparam logic [1:0] S_G  = ASP_G;
    localparam logic [1:0] S_Y  = ASP_Y;
    localparam logic [1:0] S_R  = ASP_R;

    localparam int TW = $clog2(MAX_G_TICKS + 1);
    localparam logic [TW-1:0] MAX_SAT = TW'(MAX_G_TICKS);
    localparam logic [TW:0]   RY_T    = (TW+1)'(RY_TICKS);
    localparam logic [TW:0]   MIN_T   = (TW+1)'(MIN_G_TICKS);
    localparam logic [TW:0]   MAX_T   = (TW+1)'(MAX_G_TICKS);
    localparam logic [TW:0]   Y_T     = (TW+1)'(Y_TICKS);
    localparam logic [TW:0]   R_T     = (TW+1)'(R_TICKS);
    localparam logic [1:0]    REST    = 2'(REST_PHASE);

    logic [1:0]    state, state_nx, phase_nx;
    logic [2:0]    dem, dem_nx, req_mask;
    logic [TW-1:0] tcnt;
    logic [TW:0]   elapsed;
    logic [1:0]    p1, p2;
    logic          tick, restart, pre_act, pre_other, other, enter_g;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Elapsed ticks including the one completing this cycle, so an N-tick state exits on its last clock.
    assign elapsed = {1'b0, tcnt} + {{TW{1'b0}}, tick};

    always_comb begin
        pre_act   = preempt && (preempt_phase != 2'd3);
        pre_other = pre_act && (preempt_phase != phase);
        other     = |(dem & ~phase_onehot(phase));
        p1        = phase_inc(phase);
        p2        = phase_inc(p1);
        state_nx  = state;
        phase_nx  = phase;
        case (state)
            S_R: begin
                if (elapsed >= R_T) begin
                    state_nx = S_RY;
                    if (pre_act)         phase_nx = preempt_phase;
                    else if (dem[p1])    phase_nx = p1;
                    else if (dem[p2])    phase_nx = p2;
                    else if (dem[phase]) phase_nx = phase;
                    else                 phase_nx = REST;
                end
            end
            S_RY: begin
                if (pre_other)            state_nx = S_Y;
                else if (elapsed >= RY_T) state_nx = S_G;
            end
            S_G: begin
                if (pre_act) begin
                    if (pre_other) state_nx = S_Y;
                end else if (elapsed >= MIN_T && other &&
                             (!req[phase] || elapsed >= MAX_T)) begin
                    state_nx = S_Y;
                end
            end
            S_Y: begin
                if (elapsed >= Y_T) state_nx = S_R;
            end
        endcase
        restart = (state_nx != state);
        enter_g = (state_nx == S_G) && (state != S_G);
        // The phase being served does not re-register its own demand; clearing beats setting.
        req_mask = (state == S_G) ? ~phase_onehot(phase) : 3'b111;
        dem_nx   = dem | (req & req_mask);
        if (enter_g) dem_nx = dem_nx & ~phase_onehot(phase);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_R;
            phase  <= REST;
            dem    <= 3'b000;
            tcnt   <= '0;
            grant  <= 3'b000;
            served <= 1'b0;
        end else begin
            state  <= state_nx;
            phase  <= phase_nx;
            dem    <= dem_nx;
            served <= enter_g;
            grant  <= (state_nx == S_R) ? 3'b000 : phase_onehot(phase_nx);
            if (restart) begin
                tcnt <= '0;
            end else if (tick && tcnt != MAX_SAT) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign aspect = state;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// tb/tb_junction_phase_scheduler.sv - scoreboard bench for junction_phase_scheduler
module tb_junction_phase_scheduler;

    localparam logic [1:0] A_RY = 2'd0;
    localparam logic [1:0] A_G  = 2'd1;
    localparam logic [1:0] A_Y  = 2'd2;
    localparam logic [1:0] A_R  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic       preempt = 1'b0;
    logic [1:0] preempt_phase = 2'd3;
    logic [1:0] phase;
    logic [1:0] aspect;
    logic [2:0] grant;
    logic       served;

    typedef struct {
        logic [1:0] ph;
        logic [1:0] asp;
        logic [2:0] gr;
        logic       sv;
        int         dwell;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         vectors = 0;
    int         miscompares = 0;
    int         dwell = 1;
    int         t = 0;
    logic [3:0] last_pa = {2'd0, 2'd3};
    bit         mon_en = 1'b0;
    bit         first = 1'b1;
    bit         done = 1'b0;

    junction_phase_scheduler #(
        .TICK_DIV    (4),
        .RY_TICKS    (1),
        .MIN_G_TICKS (4),
        .MAX_G_TICKS (16),
        .Y_TICKS     (1),
        .R_TICKS     (1),
        .REST_PHASE  (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .preempt       (preempt),
        .preempt_phase (preempt_phase),
        .phase         (phase),
        .aspect        (aspect),
        .grant         (grant),
        .served        (served)
    );

    always #5 clk = ~clk;

    // dwell_exp is the clock count of the state being left; 0 means not checked.
    task automatic push(input logic [1:0] ph, input logic [1:0] asp, input logic sv, input int dwell_exp);
        exp_t x;
        x.ph    = ph;
        x.asp   = asp;
        x.gr    = (asp == A_R) ? 3'b000 : (3'b001 << ph);
        x.sv    = sv;
        x.dwell = dwell_exp;
        exp_q.push_back(x);
    endtask

    task automatic wait_to(input int n);
        while (t < n) begin
            @(negedge clk);
            t++;
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_transition: never saw phase=%0d aspect=%0d", e.ph, e.asp);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else if (mon_en) begin
            if (first) begin
                first = 1'b0;
                vectors++;
                if (phase !== 2'd0 || aspect !== A_R || grant !== 3'b000 || served !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_state: got phase=%0d aspect=%0d grant=%b served=%b, expected 0 3 000 0",
                             phase, aspect, grant, served);
                end
            end else if ({phase, aspect} !== last_pa) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_transition at t=%0d: got phase=%0d aspect=%0d after %0d clocks",
                             t, phase, aspect, dwell);
                end else begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (phase !== e.ph || aspect !== e.asp || grant !== e.gr || served !== e.sv ||
                        (e.dwell != 0 && dwell != e.dwell)) begin
                        miscompares++;
                        $display("FAIL vector %0d at t=%0d: got phase=%0d aspect=%0d grant=%b served=%b dwell=%0d, expected phase=%0d aspect=%0d grant=%b served=%b dwell=%0d",
                                 vectors, t, phase, aspect, grant, served, dwell,
                                 e.ph, e.asp, e.gr, e.sv, e.dwell);
                    end
                end
                last_pa = {phase, aspect};
                dwell   = 1;
            end else begin
                dwell++;
                if (served !== 1'b0) begin
                    miscompares++;
                    $display("FAIL served_stray at t=%0d: got served=%b, expected 0", t, served);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        // Reset release: R, phase 0 RY, G; single pulse on req[2] during early green.
        push(2'd0, A_RY, 1'b0, 0);
        push(2'd0, A_G,  1'b1, 4);
        push(2'd0, A_Y,  1'b0, 16);
        push(2'd0, A_R,  1'b0, 4);
        push(2'd2, A_RY, 1'b0, 4);
        push(2'd2, A_G,  1'b1, 4);
        wait_to(9);   req = 3'b100;
        wait_to(10);  req = 3'b000;
        // Phase 2 rests in green well past max-green, then demand on 0 ends it.
        wait_to(136);
        push(2'd2, A_Y,  1'b0, 102);
        push(2'd2, A_R,  1'b0, 4);
        push(2'd0, A_RY, 1'b0, 4);
        push(2'd0, A_G,  1'b1, 4);
        req = 3'b001;
        wait_to(137); req = 3'b000;
        // Max-green: own demand held while phase 1 waits.
        wait_to(151);
        push(2'd0, A_Y,  1'b0, 64);
        push(2'd0, A_R,  1'b0, 4);
        push(2'd1, A_RY, 1'b0, 4);
        push(2'd1, A_G,  1'b1, 4);
        req = 3'b011;
        wait_to(152); req = 3'b001;
        wait_to(214); req = 3'b000;
        // Back to phase 0, then simultaneous demand on 1 and 2.
        wait_to(230);
        push(2'd1, A_Y,  1'b0, 16);
        push(2'd1, A_R,  1'b0, 4);
        push(2'd0, A_RY, 1'b0, 4);
        push(2'd0, A_G,  1'b1, 4);
        req = 3'b001;
        wait_to(231); req = 3'b000;
        wait_to(256);
        push(2'd0, A_Y,  1'b0, 16);
        push(2'd0, A_R,  1'b0, 4);
        push(2'd1, A_RY, 1'b0, 4);
        push(2'd1, A_G,  1'b1, 4);
        push(2'd1, A_Y,  1'b0, 16);
        push(2'd1, A_R,  1'b0, 4);
        push(2'd2, A_RY, 1'b0, 4);
        push(2'd2, A_G,  1'b1, 4);
        req = 3'b110;
        wait_to(257); req = 3'b000;
        // Preemption to phase 2 on the first cycle of phase 0 green.
        wait_to(340);
        push(2'd2, A_Y,  1'b0, 32);
        push(2'd2, A_R,  1'b0, 4);
        push(2'd0, A_RY, 1'b0, 4);
        push(2'd0, A_G,  1'b1, 4);
        req = 3'b001;
        wait_to(341); req = 3'b000;
        wait_to(354);
        push(2'd0, A_Y,  1'b0, 1);
        push(2'd0, A_R,  1'b0, 4);
        push(2'd2, A_RY, 1'b0, 4);
        push(2'd2, A_G,  1'b1, 4);
        preempt = 1'b1; preempt_phase = 2'd2;
        wait_to(370); req = 3'b101;
        wait_to(450);
        push(2'd2, A_Y,  1'b0, 84);
        push(2'd2, A_R,  1'b0, 4);
        push(2'd0, A_RY, 1'b0, 4);
        push(2'd0, A_G,  1'b1, 4);
        preempt = 1'b0; preempt_phase = 2'd3; req = 3'b000;
        // Reset during yellow drops pending demand; preempt_phase 3 is ignored.
        wait_to(470);
        push(2'd0, A_Y,  1'b0, 16);
        push(2'd0, A_R,  1'b0, 2);
        push(2'd0, A_RY, 1'b0, 4);
        push(2'd0, A_G,  1'b1, 4);
        req = 3'b010;
        wait_to(471); req = 3'b000;
        wait_to(480); rst_n = 1'b0;
        wait_to(481); rst_n = 1'b1;
        wait_to(482); preempt = 1'b1; preempt_phase = 2'd3;
        wait_to(530);
        done = 1'b1;
    end

endmodule

// File: doc/junction_phase_scheduler.md
# junction_phase_scheduler

Demand-actuated phase scheduler for the three-phase T-junction. It latches vehicle-detector requests and picks the next phase round-robin, skipping phases with no demand. It enforces RY/min-green/max-green/yellow/all-red timing and supports a single emergency preemption input. Its outputs (`phase`, `aspect`) drive the junction lamp decoder in place of a fixed-cycle sequencer.

## Interface
- `TICK_DIV`, 25_000_000: clocks per timing tick (0.25 s at 100 MHz).
- `RY_TICKS`, 1: red-yellow duration in ticks.
- `MIN_G_TICKS`, 4: minimum green in ticks.
- `MAX_G_TICKS`, 16: maximum green in ticks while conflicting demand is pending.
- `Y_TICKS`, 1: yellow duration in ticks.
- `R_TICKS`, 1: all-red clearance in ticks.
- `REST_PHASE`, 0: phase served when no demand exists.
- Constraints: every duration ≥ 1; `MIN_G_TICKS` ≤ `MAX_G_TICKS`; `REST_PHASE` ≤ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  3  detector demand per phase, level, synchronous.
- `preempt`  in  1  emergency preemption request, level.
- `preempt_phase`  in  2  phase to force; value 3 ignores `preempt`.
- `phase`  out  2  currently selected phase (0..2).
- `aspect`  out  2  aspect of the selected phase: 00 RY, 01 G, 10 Y, 11 R. All other phases are red.
- `grant`  out  3  one-hot of `phase` while aspect ≠ R; 0 during all-red.
- `served`  out  1  one-cycle pulse on entry to G.

## Operation
- Reset values: `phase` = `REST_PHASE`, `aspect` = R, `grant` = 0, `served` = 0, demand register = 0, timers = 0. Operation starts in S_R.
- FSM states: S_RY, S_G, S_Y, S_R. `aspect` mirrors the state.
- Demand register `dem[2:0]`:
  - `dem[i]` sets while `req[i]` = 1.
  - `dem[phase]` clears on entry to S_G.
  - While in S_G, `req[phase]` is not latched.
  - Set and clear on the same cycle: clear wins.
- S_R: on expiry, select the next phase and go to S_RY.
  - If `preempt` is active, select `preempt_phase`.
  - Else select the first set `dem` bit, searching `phase+1`, `phase+2`, `phase` (mod 3).
  - Else select `REST_PHASE`.
- S_RY → S_G after `RY_TICKS`.
- S_G:
  - `other` = any `dem` bit set, excluding `phase`.
  - After `MIN_G_TICKS`, go to S_Y when `other` && (!`req[phase]` || elapsed ≥ `MAX_G_TICKS`).
  - With no `other`, rest in green indefinitely.
- S_Y → S_R after `Y_TICKS`.
- Preemption, with `preempt` = 1 and `preempt_phase` = p ≠ 3:
  - In S_RY or S_G with `phase` ≠ p: go to S_Y on the next clock, ignoring min-green.
  - S_Y and S_R complete normally.
  - While `phase` = p and in S_G, hold green, ignoring max-green and `other`.
- Timing: the prescaler and tick counter restart on every state change, so a state of N ticks lasts exactly N·`TICK_DIV` clocks.

## Timing
- All outputs are registered. A transition condition true at edge k produces new outputs after edge k.
- `served` is high for exactly the first cycle of S_G.
- A preempt-forced S_G/S_RY → S_Y takes one clock from `preempt` being sampled high.
- Reset mid-operation: the next cycle after `rst_n` is sampled low shows reset values, whatever the state.
- Tick counter width is `$clog2(MAX_G_TICKS+1)`. It saturates at `MAX_G_TICKS` and does not wrap during rest-in-green.
- Prescaler width is `$clog2(TICK_DIV)`. It wraps at `TICK_DIV-1`.

## Structure
- Shared package `junction_pkg`:
  - phase constants PHASE1..PHASE3 = 0..2.
  - aspect enum (RY, G, Y, R as above).
  - 3-bit lamp codes RED 100, YELLOW 010, GREEN 001, RED_YELLOW 110.
- Sub-module `tick_prescaler`: counter with synchronous `restart`, `tick` output, parameter `TICK_DIV`.
- Round-robin pick and FSM stay inline.

## Test plan
All tests use `TICK_DIV`=4 and default durations.
- Reset release, no `req` → `aspect` R for 4 clocks, then phase 0 RY 4 clocks, then G held indefinitely; `served` pulses once.
- Resting in phase 0 G, pulse `req[2]` 1 cycle at cycle 2 of G → G lasts 16 clocks (min-green), then Y 4, R 4, then phase 2 RY; `dem[2]` clears on phase 2 G.
- Phase 0 G with `req[0]` held and `req[1]` set → Y starts at exactly 64 clocks of G (max-green); next phase is 1.
- Demands on 1 and 2 simultaneously while phase 0 serves → order is 1 then 2; phase 0 does not reappear while `req[0]` = 0.
- `preempt`=1, `preempt_phase`=2 during phase 0 G at cycle 1 → Y the next clock, then R, then phase 2 RY/G; green holds past 64 clocks while `preempt` stays high.
- `rst_n` low for 1 cycle during Y → next cycle `phase`=0, `aspect`=R, `grant`=0, `dem`=0; `preempt_phase`=3 with `preempt`=1 → no effect.
